// File: rtl/cfgwr_pkg.sv
// Shared types for the AXI4-Lite configuration writer: FSM state encoding and
// AXI write-response codes.
package cfgwr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    FAULT  = 2'd3
  } cfgwr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axilite_config_writer.sv
// AXI4-Lite write-only initiator: one AW/W/B write per accepted request.
// Optional B-wait watchdog with sticky FAULT state: define CFGWR_TIMEOUT_EN.
module axilite_config_writer
  import cfgwr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [DATA_WIDTH/8-1:0]    req_strb,
  output logic                       done_valid,
  output logic [1:0]                 done_resp,
  output logic                       done_timeout,
  output logic                       busy,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  output logic                       m_axilite_config_awvalid,
  input  logic                       m_axilite_config_awready,
  output logic [ADDR_WIDTH-1:0]      m_axilite_config_awaddr,
  output logic                       m_axilite_config_wvalid,
  input  logic                       m_axilite_config_wready,
  output logic [DATA_WIDTH-1:0]      m_axilite_config_wdata,
  output logic [DATA_WIDTH/8-1:0]    m_axilite_config_wstrb,
  input  logic                       m_axilite_config_bvalid,
  output logic                       m_axilite_config_bready,
  input  logic [1:0]                 m_axilite_config_bresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  if (((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("axilite_config_writer: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES >= 1");
  end

  cfgwr_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      req_ready_q, req_ready_d;
  logic                      done_valid_q, done_valid_d;
  logic [1:0]                done_resp_q, done_resp_d;
  logic                      busy_q, busy_d;
  logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                      err_evt;

`ifdef CFGWR_TIMEOUT_EN
  localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_WIDTH-1:0]      timer_q, timer_d;
  logic                      done_timeout_q, done_timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    req_ready_d  = req_ready_q;
    done_valid_d = 1'b0;
    done_resp_d  = done_resp_q;
    err_evt      = 1'b0;
`ifdef CFGWR_TIMEOUT_EN
    timer_d        = timer_q;
    done_timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          data_d      = req_data;
          strb_d      = req_strb;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          req_ready_d = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // A channel whose valid is already low has completed its handshake.
        if (awvalid_q && m_axilite_config_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axilite_config_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WAIT_B;
`ifdef CFGWR_TIMEOUT_EN
          timer_d  = '0;
`endif
        end
      end
      WAIT_B: begin
        if (bready_q && m_axilite_config_bvalid) begin
          bready_d     = 1'b0;
          done_valid_d = 1'b1;
          done_resp_d  = m_axilite_config_bresp;
          err_evt      = (m_axilite_config_bresp != RESP_OKAY);
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
`ifdef CFGWR_TIMEOUT_EN
        else if (timer_q == TMR_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          bready_d       = 1'b0;
          done_valid_d   = 1'b1;
          done_timeout_d = 1'b1;
          done_resp_d    = RESP_SLVERR;
          err_evt        = 1'b1;
          state_d        = FAULT;
        end else begin
          timer_d = timer_q + TMR_WIDTH'(1);
        end
`endif
      end
      FAULT: begin
        // Sticky until reset so a late B cannot be credited to a new request.
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    err_count_d = (err_evt && (err_count_q != ERR_MAX)) ? err_count_q + 1'b1 : err_count_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      done_valid_q <= 1'b0;
      done_resp_q  <= RESP_OKAY;
      busy_q       <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      req_ready_q  <= req_ready_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
      busy_q       <= busy_d;
      err_count_q  <= err_count_d;
    end
  end

`ifdef CFGWR_TIMEOUT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timer_q        <= '0;
      done_timeout_q <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      done_timeout_q <= done_timeout_d;
    end
  end
  assign done_timeout = done_timeout_q;
`else
  assign done_timeout = 1'b0;
`endif

  assign req_ready               = req_ready_q;
  assign done_valid              = done_valid_q;
  assign done_resp               = done_resp_q;
  assign busy                    = busy_q;
  assign err_count               = err_count_q;
  assign m_axilite_config_awvalid = awvalid_q;
  assign m_axilite_config_awaddr  = addr_q;
  assign m_axilite_config_wvalid  = wvalid_q;
  assign m_axilite_config_wdata   = data_q;
  assign m_axilite_config_wstrb   = strb_q;
  assign m_axilite_config_bready  = bready_q;

endmodule

// File: tb/tb_axilite_config_writer.sv
// Self-checking bench for axilite_config_writer: directed and randomized writes
// against a procedural AXI-Lite slave; watchdog steps run when CFGWR_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_axilite_config_writer;
  import cfgwr_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 3;
  localparam int TO = 16;
  localparam int ERR_SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [SW-1:0] req_strb = '0;
  logic          done_valid;
  logic [1:0]    done_resp;
  logic          done_timeout;
  logic          busy;
  logic [EW-1:0] err_count;
  logic          awvalid, awready = 1'b0;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready = 1'b0;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid = 1'b0, bready;
  logic [1:0]    bresp = 2'b00;

  always #5 clk = ~clk;

  axilite_config_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .done_valid(done_valid), .done_resp(done_resp), .done_timeout(done_timeout),
    .busy(busy), .err_count(err_count),
    .m_axilite_config_awvalid(awvalid), .m_axilite_config_awready(awready),
    .m_axilite_config_awaddr(awaddr),
    .m_axilite_config_wvalid(wvalid), .m_axilite_config_wready(wready),
    .m_axilite_config_wdata(wdata), .m_axilite_config_wstrb(wstrb),
    .m_axilite_config_bvalid(bvalid), .m_axilite_config_bready(bready),
    .m_axilite_config_bresp(bresp)
  );

  int vectors = 0;
  int miscompares = 0;
  int err_model = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_error(input bit is_err);
    if (is_err && err_model < ERR_SAT) err_model++;
  endfunction

  // Starts and ends on a falling edge; ends on the cycle the completion is visible.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int awd, input int wdd, input int bd,
                          input logic [1:0] resp, input bit early_b);
    int  cyc, sc;
    bit  aw_seen, w_seen, aw_v, w_v;
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1; req_addr = a; req_data = d; req_strb = s;
    @(negedge clk);
    cyc = 1;
    req_valid = 1'b0; req_addr = AW'($urandom); req_data = $urandom; req_strb = SW'($urandom);
    aw_seen = 0; w_seen = 0; sc = 0;
    while (!(aw_seen && w_seen) && sc < 40) begin
      chk("send_req_ready", req_ready, 0);
      chk("send_busy", busy, 1);
      chk("send_awvalid", awvalid, !aw_seen);
      chk("send_wvalid", wvalid, !w_seen);
      chk("send_bready", bready, 0);
      chk("send_done", done_valid, 0);
      if (!aw_seen) chk("awaddr", awaddr, a);
      if (!w_seen) begin
        chk("wdata", wdata, d);
        chk("wstrb", wstrb, s);
      end
      aw_v = awvalid; w_v = wvalid;
      awready = (sc >= awd); wready = (sc >= wdd);
      bvalid = early_b; bresp = ~resp;
      @(negedge clk);
      cyc++; sc++;
      if (aw_v && awready) aw_seen = 1;
      if (w_v && wready)   w_seen = 1;
    end
    chk("send_handshakes", aw_seen && w_seen, 1);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    for (int k = 0; k <= bd; k++) begin
      chk("wait_bready", bready, 1);
      chk("wait_done", done_valid, 0);
      chk("wait_awvalid", awvalid, 0);
      bvalid = (k == bd);
      bresp  = (k == bd) ? resp : ~resp;
      @(negedge clk);
      cyc++;
    end
    bvalid = 1'b0;
    model_error(resp != RESP_OKAY);
    chk("done_valid", done_valid, 1);
    chk("done_resp", done_resp, resp);
    chk("done_timeout", done_timeout, 0);
    chk("err_count", err_count, err_model);
    chk("done_req_ready", req_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_bready", bready, 0);
    chk("latency", cyc, 3 + ((awd > wdd) ? awd : wdd) + bd);
    $display("txn addr=0x%03h data=0x%08h strb=0x%h awd=%0d wd=%0d bd=%0d resp=%0b early_b=%0d err=%0d",
             a, d, s, awd, wdd, bd, resp, early_b, err_count);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_done_drop", done_valid, 0);
    chk("idle_ready", req_ready, 1);
  endtask

  initial begin
    int awd, wdd, bd, nb;
    logic [1:0] r;

    // Reset values while ap_rst_n is held low.
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_resp", done_resp, 0);
    chk("rst_done_timeout", done_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Always-ready slave, OKAY response, minimum latency.
    do_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, RESP_OKAY, 0);
    idle_cycle();
    // W ready delayed by four cycles, AW immediate.
    do_write(12'h024, 32'h12345678, 4'h3, 0, 4, 1, RESP_OKAY, 0);
    idle_cycle();
    // Three SLVERR then one DECERR, back to back.
    do_write(12'h100, 32'h1, 4'hF, 0, 0, 0, RESP_SLVERR, 0);
    do_write(12'h104, 32'h2, 4'hF, 1, 0, 0, RESP_SLVERR, 0);
    do_write(12'h108, 32'h3, 4'hF, 0, 1, 2, RESP_SLVERR, 0);
    do_write(12'h10C, 32'h4, 4'hF, 2, 2, 0, RESP_DECERR, 0);
    chk("err_after_four", err_count, 4);
    // More errors, including EXOKAY, push the counter to saturation.
    do_write(12'h110, 32'h5, 4'h1, 0, 0, 0, RESP_EXOKAY, 0);
    do_write(12'h114, 32'h6, 4'h2, 0, 0, 0, RESP_SLVERR, 0);
    do_write(12'h118, 32'h7, 4'h4, 0, 0, 0, RESP_DECERR, 0);
    do_write(12'h11C, 32'h8, 4'h8, 0, 0, 0, RESP_SLVERR, 0);
    chk("err_saturated", err_count, ERR_SAT);
    // Premature bvalid throughout SEND must not complete the write.
    do_write(12'h200, 32'hA5A5A5A5, 4'hF, 3, 3, 2, RESP_OKAY, 1);
    idle_cycle();

    // Asynchronous reset in the middle of SEND.
    req_valid = 1'b1; req_addr = 12'h300; req_data = 32'hCAFEF00D; req_strb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("prerst_awvalid", awvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_awvalid", awvalid, 0);
    chk("arst_wvalid", wvalid, 0);
    chk("arst_bready", bready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_err_count", err_count, 0);
    chk("arst_done_resp", done_resp, 0);
    err_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_write(12'h304, 32'h0BADC0DE, 4'hC, 0, 0, 0, RESP_OKAY, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      awd = $urandom_range(0, 4);
      wdd = $urandom_range(0, 4);
      bd  = $urandom_range(0, 3);
      r   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : RESP_OKAY;
      do_write(AW'($urandom), $urandom, SW'($urandom), awd, wdd, bd, r, bit'($urandom_range(0, 1)));
      nb = $urandom_range(0, 2);
      for (int i = 0; i < nb; i++) idle_cycle();
    end

`ifdef CFGWR_TIMEOUT_EN
    // B never arrives: watchdog fires after TO cycles of bready, then FAULT is sticky.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h400; req_data = 32'h55AA55AA; req_strb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    nb = 0;
    for (int i = 0; i < 200 && !done_valid; i++) begin
      if (bready) nb++;
      @(negedge clk);
    end
    model_error(1'b1);
    chk("to_done_valid", done_valid, 1);
    chk("to_cycles", nb, TO);
    chk("to_done_timeout", done_timeout, 1);
    chk("to_done_resp", done_resp, RESP_SLVERR);
    chk("to_err_count", err_count, err_model);
    chk("to_bready", bready, 0);
    req_valid = 1'b1; bvalid = 1'b1; bresp = RESP_OKAY;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fault_req_ready", req_ready, 0);
      chk("fault_busy", busy, 1);
      chk("fault_done", done_valid, 0);
      chk("fault_bready", bready, 0);
    end
    req_valid = 1'b0; bvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    err_model = 0;
    @(negedge clk);
    do_write(12'h408, 32'h600DF00D, 4'hF, 0, 0, 0, RESP_OKAY, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axilite_config_writer.md
Name: axilite_config_writer

Overview:
- AXI4-Lite write-only initiator (master) that drives the config slave port of a kernel, using AW, W and B channels only.
- Accepts single register-write requests on a valid/ready request port and issues one AXI-Lite write per request.
- Waits for the B response, then reports completion status and keeps a saturating error count.
- Sits in the kernel test/integration harness and the host-side shell, in front of any kernel's s_axilite_* config port.

Parameters:
- ADDR_WIDTH, 12, AW address width.
- DATA_WIDTH, 32, W data width; must be 32 or 64.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- TIMEOUT_CYCLES, 256, B-wait watchdog limit; used only with CFGWR_TIMEOUT_EN.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_addr  in  ADDR_WIDTH  target register byte address.
- req_data  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  byte strobes.
- done_valid  out  1  one-cycle completion pulse.
- done_resp  out  2  captured BRESP (00 OKAY, 10 SLVERR, 11 DECERR).
- done_timeout  out  1  completion was a watchdog abort; tied 0 without the feature.
- busy  out  1  high in any state other than IDLE.
- err_count  out  ERR_CNT_WIDTH  saturating count of non-OKAY responses and timeouts.
- m_axilite_config_awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH  AW channel.
- m_axilite_config_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  W channel.
- m_axilite_config_bvalid/bready/bresp  in/out/in  1/1/2  B channel.

Behaviour:
- Reset values (async, ap_rst_n low): state IDLE, req_ready=1, all AXI valids=0, bready=0, done_valid=0, done_resp=00, done_timeout=0, busy=0, err_count=0. All outputs are registered.
- Reset mid-transaction: immediately returns to IDLE. An outstanding slave transaction is abandoned; the slave is expected to share the reset.
- States: IDLE, SEND, WAIT_B, FAULT (FAULT is reachable only with the feature).
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/data/strb; next cycle enter SEND with awvalid=wvalid=1 and req_ready=0.
- SEND:
  - AW and W complete independently. Each valid drops the cycle after its own handshake (aw_done/w_done flags).
  - A valid never deasserts before its handshake; addr/data/strb stay stable while valid.
  - AW and W handshakes in the same cycle are legal, as is either order.
  - When both are done, enter WAIT_B with bready=1.
  - bready=0 throughout SEND, so a premature bvalid is ignored.
- WAIT_B:
  - On bvalid&bready: capture bresp and drop bready.
  - Next cycle: done_valid=1 for one cycle, state IDLE, req_ready=1.
- Latency with an always-ready slave:
  - cycle 0: request accepted.
  - cycle 1: AW and W handshake.
  - cycle 2: bready high; B handshake if bvalid.
  - cycle 3: done_valid high; next request acceptable in the same cycle.
- err_count increments on a done pulse whose bresp is not OKAY, or which is a timeout, and holds at all-ones.
- bresp=01 (EXOKAY) is treated as an error, since AXI-Lite forbids it.
- Back-to-back operation: a request presented while done_valid is high is accepted that cycle.

Optional Feature:
- Macro: CFGWR_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_B and counts cycles with bvalid low.
  - At TIMEOUT_CYCLES it forces bready=0, pulses done_valid with done_timeout=1 and done_resp=10, increments err_count, and enters FAULT.
  - FAULT holds req_ready=0 and busy=1 until reset. This prevents a late B being mis-attributed to a later request.
- When undefined: no counter, no FAULT state; WAIT_B waits indefinitely and done_timeout is constant 0.

Decomposition:
- Package cfgwr_pkg holds:
  - the state enum (IDLE, SEND, WAIT_B, FAULT);
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- No sub-module is required. The watchdog may optionally be split out as cfgwr_watchdog, compiled only under CFGWR_TIMEOUT_EN.

Test Plan:
- Always-ready slave, request addr 0x010, data 0xDEADBEEF, strb 0xF, bresp=00: AW/W seen in cycle 1, done_valid in cycle 3 with done_resp=00, err_count=0.
- wready delayed 4 cycles, awready immediate: awvalid drops after 1 cycle; wvalid is held with wdata stable until the handshake; bready is never high before the W handshake; done_valid fires once.
- Slave returns bresp=10 on three writes, then 11 on one: err_count=4. With ERR_CNT_WIDTH=2 and 5 errors, err_count saturates at 3.
- bvalid driven high during SEND, before the W handshake: no B handshake occurs; a completion is reported only after a proper B in WAIT_B.
- ap_rst_n pulsed low mid-SEND: all valids drop asynchronously, outputs return to reset values, and the next request completes normally.
- With CFGWR_TIMEOUT_EN and TIMEOUT_CYCLES=16, bvalid held at 0: done_timeout=1 and done_resp=10 at 16 cycles, err_count=1; req_ready stays 0 until reset.
